// File: rtl/up_down_counter_sequencer_if.sv
// Control/feedback bundle between the sweep sequencer and the external
// up/down counter datapath. The sequencer is the master: it drives load,
// enable and direction and reads back the count and zero flag.
interface up_down_counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_en;
  logic             cnt_up;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_zero;

  modport master (
    output cnt_load,
    output cnt_in,
    output cnt_en,
    output cnt_up,
    input  cnt_count,
    input  cnt_zero
  );

  modport slave (
    input  cnt_load,
    input  cnt_in,
    input  cnt_en,
    input  cnt_up,
    output cnt_count,
    output cnt_zero
  );
endinterface

// File: rtl/up_down_counter_sequencer.sv
// Sweep sequencer for an external up/down counter. Each pass loads a start
// value, counts up to the limit, then down to zero. A watchdog flags a stall
// when the counter stops following its enable. Status outputs are registered;
// cnt_en is combinational so abort and pause gate it in the same cycle.
module up_down_counter_sequencer #(
  parameter int WIDTH       = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        pause,
  input  logic [WIDTH-1:0]            cfg_start,
  input  logic [WIDTH-1:0]            cfg_limit,
  input  logic [3:0]                  cfg_passes,
  up_down_counter_sequencer_if.master cnt,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [3:0]                  pass_idx
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] STALL_MAX = 4'(STALL_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_val_q, start_val_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [3:0]       passes_q, passes_d;
  logic [3:0]       pass_idx_q, pass_idx_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             en_prev_q, en_prev_d;
  logic [3:0]       stall_q, stall_d;
  logic             cnt_load_q, cnt_load_d;
  logic [WIDTH-1:0] cnt_in_q, cnt_in_d;
  logic             cnt_up_q, cnt_up_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_en_s;
  logic             stall_hit_s;
  logic [3:0]       stall_inc_s;
  logic             last_pass_s;

  // Count enable: only in UP/DOWN, stops at the turn-around points, gated by pause and abort
  always_comb begin
    cnt_en_s = 1'b0;
    if (abort) begin
      cnt_en_s = 1'b0;
    end else if (state_q == S_UP) begin
      cnt_en_s = (cnt.cnt_count != limit_q) && !pause;
    end else if (state_q == S_DOWN) begin
      cnt_en_s = !cnt.cnt_zero && !pause;
    end else begin
      cnt_en_s = 1'b0;
    end
  end

  // Watchdog and pass bookkeeping helpers
  always_comb begin
    stall_hit_s = en_prev_q && (cnt.cnt_count == prev_count_q);
    stall_inc_s = stall_hit_s ? (stall_q + 4'd1) : 4'd0;
    last_pass_s = (({1'b0, pass_idx_q} + 5'd1) >= {1'b0, passes_q});
  end

  // Next-state, configuration latch, watchdog and registered-output computation
  always_comb begin
    state_d      = state_q;
    start_val_d  = start_val_q;
    limit_d      = limit_q;
    passes_d     = passes_q;
    pass_idx_d   = pass_idx_q;
    prev_count_d = cnt.cnt_count;
    en_prev_d    = cnt_en_s;
    stall_d      = 4'd0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_val_d = cfg_start;
            limit_d     = cfg_limit;
            passes_d    = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
            pass_idx_d  = 4'd0;
            if (cfg_start > cfg_limit) begin
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          state_d = S_UP;
        end
        S_UP: begin
          if (pause) begin
            stall_d = stall_q;
          end else begin
            stall_d = stall_inc_s;
            if (stall_inc_s >= STALL_MAX) begin
              state_d = S_ERR;
            end else if (cnt.cnt_count == limit_q) begin
              state_d = S_DOWN;
            end else begin
              state_d = S_UP;
            end
          end
        end
        S_DOWN: begin
          if (pause) begin
            stall_d = stall_q;
          end else begin
            stall_d = stall_inc_s;
            if (stall_inc_s >= STALL_MAX) begin
              state_d = S_ERR;
            end else if (cnt.cnt_zero) begin
              if (last_pass_s) begin
                state_d = S_DONE;
              end else begin
                pass_idx_d = pass_idx_q + 4'd1;
                state_d    = S_LOAD;
              end
            end else begin
              state_d = S_DOWN;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Status outputs follow the state being entered so they line up with it
    cnt_load_d = (state_d == S_LOAD);
    cnt_in_d   = (state_d == S_LOAD) ? start_val_d : {WIDTH{1'b0}};
    cnt_up_d   = (state_d == S_UP);
    busy_d     = (state_d == S_LOAD) || (state_d == S_UP) ||
                 (state_d == S_DOWN) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // Sequencer state, latched configuration, watchdog and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_val_q  <= {WIDTH{1'b0}};
      limit_q      <= {WIDTH{1'b0}};
      passes_q     <= 4'd0;
      pass_idx_q   <= 4'd0;
      prev_count_q <= {WIDTH{1'b0}};
      en_prev_q    <= 1'b0;
      stall_q      <= 4'd0;
      cnt_load_q   <= 1'b0;
      cnt_in_q     <= {WIDTH{1'b0}};
      cnt_up_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_val_q  <= start_val_d;
      limit_q      <= limit_d;
      passes_q     <= passes_d;
      pass_idx_q   <= pass_idx_d;
      prev_count_q <= prev_count_d;
      en_prev_q    <= en_prev_d;
      stall_q      <= stall_d;
      cnt_load_q   <= cnt_load_d;
      cnt_in_q     <= cnt_in_d;
      cnt_up_q     <= cnt_up_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cnt.cnt_load = cnt_load_q;
  assign cnt.cnt_in   = cnt_in_q;
  assign cnt.cnt_en   = cnt_en_s;
  assign cnt.cnt_up   = cnt_up_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pass_idx     = pass_idx_q;

endmodule

// File: tb/tb_up_down_counter_sequencer.sv
// Bench for up_down_counter_sequencer: a behavioural counter datapath plus a
// reference model that expands each accepted start into the list of sweep
// steps (load, every up value, every down value, done) and walks that list.
module tb_up_down_counter_sequencer;
  localparam int WIDTH       = 8;
  localparam int STALL_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] cfg_start = '0;
  logic [WIDTH-1:0] cfg_limit = '0;
  logic [3:0]       cfg_passes = '0;
  logic             busy, done, err;
  logic [3:0]       pass_idx;
  logic [WIDTH-1:0] ctr = '0;
  logic             freeze = 1'b0;

  up_down_counter_sequencer_if #(.WIDTH(WIDTH)) cnt_if ();

  up_down_counter_sequencer #(.WIDTH(WIDTH), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_passes(cfg_passes),
    .cnt(cnt_if.master), .busy(busy), .done(done), .err(err), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  // External counter datapath (freeze emulates a stuck counter)
  always @(posedge clk) begin
    if (cnt_if.cnt_load) ctr <= cnt_if.cnt_in;
    else if (cnt_if.cnt_en && !freeze) ctr <= cnt_if.cnt_up ? ctr + 8'd1 : ctr - 8'd1;
  end
  assign cnt_if.cnt_count = ctr;
  assign cnt_if.cnt_zero  = (ctr == 8'd0);

  typedef enum logic [1:0] {K_LOAD, K_UP, K_DOWN, K_DONE} kind_e;
  typedef struct {
    kind_e kind;
    int    val;
    int    pass;
    bit    en;
  } step_t;

  step_t q[$];
  bit    err_m = 1'b0;
  int    pass_m = 0;
  int    checks = 0;
  int    errors = 0;
  int    loads = 0;
  int    dones = 0;
  bit    done_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Expand one accepted start into its sweep steps
  function automatic void build(input int s, input int l, input int p);
    step_t st;
    int np;
    np = (p == 0) ? 1 : p;
    for (int k = 0; k < np; k++) begin
      st.kind = K_LOAD; st.val = s; st.pass = k; st.en = 1'b0; q.push_back(st);
      for (int v = s; v <= l; v++) begin
        st.kind = K_UP; st.val = v; st.en = (v != l); q.push_back(st);
      end
      for (int v = l; v >= 0; v--) begin
        st.kind = K_DOWN; st.val = v; st.en = (v != 0); q.push_back(st);
      end
    end
    st.kind = K_DONE; st.val = 0; st.pass = np - 1; st.en = 1'b0; q.push_back(st);
  endfunction

  // One clock: enter at negedge+1 with inputs set, check, advance the model, return at next negedge+1
  task automatic cycle();
    int exp_load, exp_in, exp_en, exp_up, exp_busy, exp_done, exp_err, exp_pass;
    step_t h;
    #1;
    exp_load = 0; exp_in = 0; exp_en = 0; exp_up = 0;
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_pass = pass_m;
    if (err_m) begin
      exp_err = 1;
    end else if (q.size() > 0) begin
      h = q[0];
      exp_pass = h.pass;
      exp_busy = 1;
      case (h.kind)
        K_LOAD: begin exp_load = 1; exp_in = h.val; end
        K_UP: begin
          exp_up = 1;
          exp_en = (h.en && !pause && !abort) ? 1 : 0;
          check_eq("cnt_count_up", cnt_if.cnt_count, h.val);
        end
        K_DOWN: begin
          exp_en = (h.en && !pause && !abort) ? 1 : 0;
          check_eq("cnt_count_down", cnt_if.cnt_count, h.val);
        end
        K_DONE: exp_done = 1;
        default: exp_busy = 0;
      endcase
    end
    check_eq("cnt_load", cnt_if.cnt_load, exp_load);
    check_eq("cnt_in", cnt_if.cnt_in, exp_in);
    check_eq("cnt_en", cnt_if.cnt_en, exp_en);
    check_eq("cnt_up", cnt_if.cnt_up, exp_up);
    check_eq("busy", busy, exp_busy);
    check_eq("done", done, exp_done);
    check_eq("err", err, exp_err);
    check_eq("pass_idx", pass_idx, exp_pass);
    if (cnt_if.cnt_load === 1'b1) loads++;
    done_seen = (done === 1'b1);
    if (done_seen) dones++;

    if (abort) begin
      if (q.size() > 0) pass_m = q[0].pass;
      q.delete();
      err_m = 1'b0;
    end else if (err_m) begin
      err_m = 1'b1;
    end else if (q.size() == 0) begin
      if (start) begin
        pass_m = 0;
        if (cfg_start > cfg_limit) err_m = 1'b1;
        else build(int'(cfg_start), int'(cfg_limit), int'(cfg_passes));
      end
    end else if (!(pause && (q[0].kind == K_UP || q[0].kind == K_DOWN))) begin
      pass_m = q[0].pass;
      void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_head(input kind_e k, input int v, input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (q.size() > 0 && q[0].kind == k && q[0].val == v && q[0].pass == p) found = 1'b1;
      else cycle();
    end
    check_eq("wait_head", found, 1);
  endtask

  // Full sweep from a start pulse; checks done timing and load/done counts
  task automatic run_sweep(input int s, input int l, input int p, input int pause_val,
                           input int pause_len, input int exp_loads);
    int cyc, done_at, paused, np, exp_len;
    np = (p == 0) ? 1 : p;
    exp_len = 1 + np * (2 * l - s + 3) + pause_len;
    cfg_start = WIDTH'(s); cfg_limit = WIDTH'(l); cfg_passes = 4'(p);
    loads = 0; dones = 0; paused = 0; done_at = -1; cyc = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cfg_start = 8'd99; cfg_limit = 8'd3; cfg_passes = 4'd9;
    for (int i = 0; i < 600 && done_at < 0; i++) begin
      if (pause_len > 0 && q.size() > 0 && q[0].kind == K_UP &&
          q[0].val == pause_val && paused < pause_len) begin
        pause = 1'b1;
        paused++;
      end else begin
        pause = 1'b0;
      end
      cyc++;
      cycle();
      if (done_seen) done_at = cyc;
    end
    pause = 1'b0;
    check_eq("done_cycle", done_at, exp_len);
    check_eq("load_pulses", loads, exp_loads);
    check_eq("done_pulses", dones, 1);
    cycle();
  endtask

  initial begin
    // Reset state
    @(negedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single pass, multi-pass, pause-extended pass
    run_sweep(60, 63, 1, 0, 0, 1);
    run_sweep(2, 4, 3, 0, 0, 3);
    run_sweep(60, 63, 1, 61, 5, 1);
    run_sweep(7, 7, 0, 0, 0, 1);
    run_sweep(0, 0, 2, 0, 0, 2);

    // Configuration error: no load, sticky until abort
    cfg_start = 8'd70; cfg_limit = 8'd63; cfg_passes = 4'd1; loads = 0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("cfg_err_loads", loads, 0);
    abort = 1'b1; cycle(); abort = 1'b0; cycle();

    // Abort during DOWN at count 30, with start in the same cycle
    cfg_start = 8'd10; cfg_limit = 8'd40; cfg_passes = 4'd1;
    start = 1'b1; cycle(); start = 1'b0;
    wait_head(K_DOWN, 30, 0);
    dones = 0;
    abort = 1'b1; start = 1'b1; cycle(); abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 60; i++) cycle();
    check_eq("abort_no_done", dones, 0);

    // Stall watchdog: counter stuck during DOWN
    cfg_start = 8'd2; cfg_limit = 8'd8; cfg_passes = 4'd1;
    start = 1'b1; cycle(); start = 1'b0;
    wait_head(K_DOWN, 7, 0);
    freeze = 1'b1;
    for (int n = 1; n <= STALL_LIMIT + 1; n++) begin
      @(posedge clk); @(negedge clk); #1;
      if (n <= STALL_LIMIT) begin
        check_eq("stall_en", cnt_if.cnt_en, 1);
        check_eq("stall_err_early", err, 0);
      end else begin
        check_eq("stall_err", err, 1);
        check_eq("stall_en_off", cnt_if.cnt_en, 0);
        check_eq("stall_busy", busy, 0);
      end
    end
    freeze = 1'b0;
    q.delete(); err_m = 1'b1; pass_m = 0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    cycle();

    // Asynchronous reset mid-UP of the second pass
    cfg_start = 8'd5; cfg_limit = 8'd30; cfg_passes = 4'd2;
    start = 1'b1; cycle(); start = 1'b0;
    wait_head(K_UP, 12, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_en", cnt_if.cnt_en, 0);
    check_eq("rst_up", cnt_if.cnt_up, 0);
    check_eq("rst_load", cnt_if.cnt_load, 0);
    check_eq("rst_in", cnt_if.cnt_in, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_pass", pass_idx, 0);
    q.delete(); err_m = 1'b0; pass_m = 0;
    @(negedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();

    // Randomized traffic against the step model
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 4) == 0;
      pause      = ($urandom % 6) == 0;
      abort      = ($urandom % 60) == 0;
      cfg_start  = WIDTH'($urandom % 12);
      cfg_limit  = WIDTH'($urandom % 21);
      cfg_passes = 4'($urandom % 4);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_down_counter_sequencer.md
Name: up_down_counter_sequencer

Overview:
Controller that sequences an external up/down counter datapath through programmed sweep passes. Each pass loads a start value, counts up to a limit, then counts down to zero. The block owns the counter's load, enable and direction controls and reads back the counter's count and zero outputs. It reports busy, done and stall-error status to the top-level control logic.

Parameters:
WIDTH, 8, counter/data width
STALL_LIMIT, 4, consecutive enabled cycles with no count change before a stall error is flagged (range 2..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  launch request; sampled in IDLE only
abort  in  1  return to IDLE from any state; takes priority over all other inputs
pause  in  1  freeze the sequence: state, pass counter and stall counter hold
cfg_start  in  WIDTH  value loaded into the counter at the start of each pass
cfg_limit  in  WIDTH  upper turn-around value
cfg_passes  in  4  number of passes; 0 is treated as 1
cnt_count  in  WIDTH  counter value fed back from the datapath
cnt_zero  in  1  counter zero flag fed back from the datapath
cnt_load  out  1  load strobe to the counter; the counter takes cnt_in at the next edge
cnt_in  out  WIDTH  load value
cnt_en  out  1  count enable; the counter moves by 1 per enabled edge
cnt_up  out  1  direction: 1 = up, 0 = down
busy  out  1  high in LOAD, UP, DOWN and DONE
done  out  1  one-cycle pulse when the final pass completes
err  out  1  sticky error flag
pass_idx  out  4  current pass number, zero-based

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, cnt_in=0, pass_idx=0, internal registers cleared. Reset mid-sweep aborts the sweep immediately and no done pulse is issued.
- Configuration: on an accepted start, cfg_start, cfg_limit and cfg_passes are latched. Later changes to the cfg inputs have no effect until the next start.
- States: IDLE, LOAD, UP, DOWN, DONE, ERR.
- IDLE, start=1:
  - If cfg_start > cfg_limit: go to ERR and set err.
  - Otherwise: go to LOAD with pass_idx=0.
- LOAD (1 cycle): cnt_load=1, cnt_in=latched start value. Next state is UP.
- UP: cnt_up=1. cnt_en = (cnt_count != limit) and not pause. When cnt_count == limit, cnt_en=0 in that same cycle and the next state is DOWN, so the counter never overshoots.
- DOWN: cnt_up=0. cnt_en = not cnt_zero and not pause. When cnt_zero=1, cnt_en=0 and:
  - If pass_idx+1 < passes: increment pass_idx and go to LOAD.
  - Otherwise: go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. pass_idx holds its final value until the next start.
- pause=1 in UP or DOWN: cnt_en=0 and the state holds. pause has no effect in IDLE, LOAD or DONE.
- Stall watchdog: active in UP and DOWN only.
  - The block registers cnt_count each cycle.
  - If cnt_en was 1 in the previous cycle and cnt_count equals the registered previous value, the stall counter increments; otherwise it clears.
  - When the stall counter reaches STALL_LIMIT, go to ERR.
- ERR: err=1, cnt_en=0, busy=0. Only abort or rst exits ERR (to IDLE, err cleared). start is ignored in ERR.
- abort=1 in any state: next state IDLE, cnt_en=0 combinationally in the same cycle, err cleared, no done pulse.
- Simultaneous start and abort in IDLE: abort wins and the block stays in IDLE.
- cfg_start == cfg_limit: UP lasts 1 cycle with cnt_en=0, then DOWN.
- cfg_limit == 0 with cfg_start == 0: UP 1 cycle, DOWN 1 cycle (cnt_zero=1), then pass complete.
- Arithmetic: all comparisons are unsigned at WIDTH bits. The sequencer never drives wrap-around, since the direction flips at limit and at zero.

Test Plan:
- Single pass, bench counter model: cfg_start=60, cfg_limit=63, cfg_passes=1, start pulsed at cycle 0 -> cnt_load=1 with cnt_in=60 at cycle 1; cnt_en high in UP for cycles 2-4; count=63 at cycle 5; DOWN cycles 6-68; cnt_zero at cycle 69; done=1 at cycle 70; busy high from cycle 1 to cycle 70.
- Multi-pass: start=2, limit=4, passes=3 -> pass_idx steps 0, 1, 2; three cnt_load pulses with cnt_in=2; exactly one done pulse, after the third zero.
- Pause: pause held for 5 cycles mid-UP at count=61 -> cnt_en=0 and count held at 61 throughout; no err raised; the sweep then completes with total length extended by exactly 5 cycles.
- Stall: counter model frozen during DOWN, STALL_LIMIT=4 -> err=1 on the 4th enabled cycle with unchanged count; cnt_en=0 afterwards; only abort clears err.
- Config error: cfg_start=70, cfg_limit=63, start -> ERR with err=1; no cnt_load pulse issued.
- Abort and reset mid-sweep: abort during DOWN at count=30 -> IDLE next cycle, cnt_en=0 in the same cycle, no done pulse. rst asserted asynchronously mid-UP -> all outputs 0 immediately.
